// File: rtl/nibble_addsub_arbiter_pkg.sv
// Shared definitions for the nibble-serial add/subtract arbiter: FSM encoding,
// slice width and the two's-complement overflow rule.
package nibble_addsub_arbiter_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow of a + b' given the sign bits of both addends and the result.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_addsub_arbiter_add4.sv
// Purely combinational 4-bit ripple-carry adder slice shared by both requesters.
module nibble_add4
    import nibble_addsub_arbiter_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_addsub_arbiter.sv
// Two-requester round-robin front end that runs full-width add/subtract through
// one shared 4-bit adder slice, one nibble per cycle, LSB first.
module nibble_addsub_arbiter
    import nibble_addsub_arbiter_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_ovf
);

    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t              state;
    logic                last_grant;
    logic                grant;
    logic                idle;
    logic                accept;
    logic [W-1:0]        sel_a;
    logic [W-1:0]        sel_b;
    logic                sel_sub;
    logic [W-1:0]        op_a;
    logic [W-1:0]        op_b;
    logic                carry;
    logic [CNT_W-1:0]    cnt;
    logic [NIBBLE_W-1:0] add_a;
    logic [NIBBLE_W-1:0] add_b;
    logic [NIBBLE_W-1:0] add_sum;
    logic                add_cout;

    // Round-robin: on a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign idle       = (state == ST_IDLE);
    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign sel_a   = grant ? req1_a   : req0_a;
    assign sel_b   = grant ? req1_b   : req0_b;
    assign sel_sub = grant ? req1_sub : req0_sub;

    // Operand capture: subtraction stores the inverted b; the +1 enters as initial carry.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= sel_a;
            op_b <= sel_b ^ {W{sel_sub}};
        end
    end

    assign add_a = op_a[NIBBLE_W * cnt +: NIBBLE_W];
    assign add_b = op_b[NIBBLE_W * cnt +: NIBBLE_W];

    nibble_add4 u_add4 (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            carry      <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_RUN;
                        last_grant <= grant;
                        carry      <= sel_sub;
                        cnt        <= '0;
                        rsp_id     <= grant;
                    end
                end
                ST_RUN: begin
                    rsp_sum[NIBBLE_W * cnt +: NIBBLE_W] <= add_sum;
                    carry <= add_cout;
                    cnt   <= cnt + 1'b1;
                    // Last slice: its carry and sign bit complete the flags.
                    if (cnt == CNT_W'(NIBBLES - 1)) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_cout  <= add_cout;
                        rsp_ovf   <= add_ovf(op_a[W-1], op_b[W-1], add_sum[NIBBLE_W-1]);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_addsub_arbiter.sv
// Randomized and directed bench for nibble_addsub_arbiter against a transaction-level model.
module tb_nibble_addsub_arbiter;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [W-1:0] rsp_sum;

    always #5 clk = ~clk;

    nibble_addsub_arbiter #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
    } op_t;

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           lat;
        int           acc_cyc;
        int           hs_cyc;
    } rsp_t;

    op_t  q0[$];
    op_t  q1[$];
    rsp_t log_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   m_inflight = 0;
    bit   m_pending  = 0;
    bit   m_last     = 1;
    int   m_busy     = 0;
    rsp_t m_exp;
    bit   rand_rdy   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic rsp_t ref_op(input logic id, input op_t op);
        rsp_t   r;
        longint ua, ub, sa, sb, lim, res;
        ua  = longint'(op.a);
        ub  = longint'(op.b);
        lim = longint'(1) << (W - 1);
        sa  = op.a[W-1] ? ua - 2 * lim : ua;
        sb  = op.b[W-1] ? ub - 2 * lim : ub;
        r   = '{id: id, sum: '0, cout: 1'b0, ovf: 1'b0, lat: 0, acc_cyc: 0, hs_cyc: 0};
        if (op.sub) begin
            r.sum  = W'(ua - ub);
            r.cout = (ua >= ub);
            res    = sa - sb;
        end else begin
            r.sum  = W'(ua + ub);
            r.cout = ((ua + ub) >= 2 * lim);
            res    = sa + sb;
        end
        r.ovf = (res >= lim) || (res < -lim);
        return r;
    endfunction

    task automatic drive_inputs();
        req0_valid = (q0.size() > 0);
        req1_valid = (q1.size() > 0);
        if (req0_valid) begin
            req0_a = q0[0].a; req0_b = q0[0].b; req0_sub = q0[0].sub;
        end else begin
            req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom);
        end
        if (req1_valid) begin
            req1_a = q1[0].a; req1_b = q1[0].b; req1_sub = q1[0].sub;
        end else begin
            req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom);
        end
    endtask

    task automatic push0(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        q0.push_back('{a: a, b: b, sub: sub});
        drive_inputs();
    endtask

    task automatic push1(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        q1.push_back('{a: a, b: b, sub: sub});
        drive_inputs();
    endtask

    // One clock: check at the falling edge, advance the model, update stimulus after the rising edge.
    task automatic cycle();
        bit   idle, e0, e1, pop0, pop1;
        op_t  op;
        rsp_t r;
        pop0 = 0;
        pop1 = 0;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            m_inflight = 0;
            m_pending  = 0;
            m_last     = 1;
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
            idle = !m_inflight && !m_pending;
            e0   = idle && req0_valid && (!req1_valid || m_last);
            e1   = idle && req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_pending));
            if (m_pending) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_exp.id));
                chk("rsp_sum", 32'(rsp_sum), 32'(m_exp.sum));
                chk("rsp_cout", 32'(rsp_cout), 32'(m_exp.cout));
                chk("rsp_ovf", 32'(rsp_ovf), 32'(m_exp.ovf));
            end
            if (rsp_valid && m_exp.lat == 0 && m_exp.acc_cyc > 0)
                m_exp.lat = cyc - m_exp.acc_cyc;
            if (m_pending && rsp_ready) begin
                r        = m_exp;
                r.hs_cyc = cyc;
                log_q.push_back(r);
                m_pending = 0;
            end else if (m_inflight) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_inflight = 0;
                    m_pending  = 1;
                end
            end else if (e0 || e1) begin
                op.a          = e0 ? req0_a   : req1_a;
                op.b          = e0 ? req0_b   : req1_b;
                op.sub        = e0 ? req0_sub : req1_sub;
                m_exp         = ref_op(e1, op);
                m_exp.acc_cyc = cyc;
                m_inflight    = 1;
                m_busy        = NIBBLES;
                m_last        = e1;
                pop0          = e0;
                pop1          = e1;
            end
        end
        @(posedge clk);
        #1;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        drive_inputs();
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_inflight || m_pending) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_rsp(input string tag, input int idx, input logic id,
                           input logic [W-1:0] sum, input logic cout, input logic ovf);
        if (idx >= log_q.size()) begin
            chk({tag, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
        end else begin
            chk({tag, "_id"}, 32'(log_q[idx].id), 32'(id));
            chk({tag, "_sum"}, 32'(log_q[idx].sum), 32'(sum));
            chk({tag, "_cout"}, 32'(log_q[idx].cout), 32'(cout));
            chk({tag, "_ovf"}, 32'(log_q[idx].ovf), 32'(ovf));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_sum"}, 32'(rsp_sum), 32'd0);
        chk({tag, "_cout"}, 32'(rsp_cout), 32'd0);
        chk({tag, "_ovf"}, 32'(rsp_ovf), 32'd0);
        chk({tag, "_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
        chk({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, sel;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        drive_inputs();
        repeat (3) cycle();
        chk_all_zero("reset");
        rst_n = 1'b1;
        cycle();

        push0(16'h1234, 16'h0FFF, 1'b0);
        drain(100);
        chk_rsp("add_basic", 0, 1'b0, 16'h2233, 1'b0, 1'b0);
        if (log_q.size() > 0) chk("latency", 32'(log_q[0].lat), 32'(NIBBLES + 1));

        push0(16'hFFFF, 16'h0001, 1'b0);
        push0(16'h7FFF, 16'h0001, 1'b0);
        drain(100);
        chk_rsp("add_wrap", 1, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk_rsp("add_ovf", 2, 1'b0, 16'h8000, 1'b0, 1'b1);

        push1(16'h0005, 16'h0007, 1'b1);
        push1(16'h8000, 16'h0001, 1'b1);
        drain(100);
        chk_rsp("sub_borrow", 3, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        chk_rsp("sub_ovf", 4, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        base = log_q.size();
        push0(16'h0100, 16'h0023, 1'b0);
        push0(16'h4000, 16'h4000, 1'b0);
        push1(16'h0050, 16'h0010, 1'b1);
        push1(16'h1000, 16'h2000, 1'b1);
        drain(200);
        chk_rsp("rr0", base,     1'b0, 16'h0123, 1'b0, 1'b0);
        chk_rsp("rr1", base + 1, 1'b1, 16'h0040, 1'b1, 1'b0);
        chk_rsp("rr2", base + 2, 1'b0, 16'h8000, 1'b0, 1'b1);
        chk_rsp("rr3", base + 3, 1'b1, 16'hF000, 1'b0, 1'b0);

        base      = log_q.size();
        rsp_ready = 1'b0;
        push1(16'h0A0A, 16'h0505, 1'b0);
        n = 0;
        while (!m_pending && n < 50) begin cycle(); n++; end
        if (n >= 50) chk("wait_done_timeout", 32'd0, 32'd1);
        push0(16'h0003, 16'h0004, 1'b0);
        repeat (3) cycle();
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_sum", 32'(rsp_sum), 32'h0F0F);
        chk("hold_rdy0", 32'(req0_ready), 32'd0);
        chk("hold_rdy1", 32'(req1_ready), 32'd0);
        rsp_ready = 1'b1;
        drain(100);
        chk_rsp("held", base, 1'b1, 16'h0F0F, 1'b0, 1'b0);
        chk_rsp("after_hold", base + 1, 1'b0, 16'h0007, 1'b0, 1'b0);
        if (log_q.size() >= base + 2)
            chk("accept_after_hs", 32'(log_q[base + 1].acc_cyc), 32'(log_q[base].hs_cyc + 1));

        push0(16'h1111, 16'h2222, 1'b0);
        n = 0;
        while (!(m_inflight && m_busy == NIBBLES - 1) && n < 50) begin cycle(); n++; end
        if (n >= 50) chk("wait_run_timeout", 32'd0, 32'd1);
        base  = log_q.size();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_rst");
        cycle();
        rst_n = 1'b1;
        push0(16'h0001, 16'h0001, 1'b0);
        drain(100);
        chk("rst_resp_count", 32'(log_q.size()), 32'(base + 1));
        chk_rsp("after_rst", base, 1'b0, 16'h0002, 1'b0, 1'b0);

        rand_rdy = 1;
        repeat (60) begin
            sel = $urandom_range(1, 3);
            if (sel[0]) push0(W'($urandom), W'($urandom), 1'($urandom));
            if (sel[1]) push1(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 6)) cycle();
        end
        drain(5000);
        rand_rdy  = 0;
        rsp_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
